dmem_cache: RTL and testbench
=============================

# dmem_cache

Direct-mapped, write-through, no-write-allocate data cache that acts as the responder to the pipeline's Memory-stage load/store port (address, write enable, funct3, write data, read data). It sits between the MEM stage and a slower backing data memory. Misses and stores become a single-word handshake to the backing memory. While a request is outstanding, `ready` is held low so the hazard logic can stall F/D/E/M.

## Interface
- `SETS`, 64: number of one-word lines; power of two, ≥2.
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: word width; fixed at 32.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-low reset; 0 at a rising edge resets.
- `req_valid`  in  1  MEM stage has a load or store this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `funct3`  in  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, LSB-aligned.
- `rdata`  out  32  load result, sign- or zero-extended.
- `ready`  out  1  request completes this cycle; 0 = stall the pipeline.
- `mem_req`  out  1  backing-memory request valid.
- `mem_we`  out  1  backing-memory write.
- `mem_addr`  out  32  word address; bits [1:0] are always 00.
- `mem_be`  out  4  byte enables for writes; 1111 for reads.
- `mem_wdata`  out  32  write data, lane-shifted.
- `mem_rdata`  in  32  backing read data, valid when `mem_ack` = 1.
- `mem_ack`  in  1  one-cycle completion pulse.

## Operation
**Address split**
- offset = `addr[1:0]`.
- index = `addr[2 +: log2(SETS)]`.
- tag = remaining upper bits.
- Each line holds one valid bit, one tag and one word.

**FSM states:** IDLE, RD_MISS, WR_THRU, RESPOND.
- **IDLE, no request:** `ready` = 1.
- **IDLE, load hit:** `ready` = 1 in the same cycle; `rdata` comes from the line.
- **IDLE, load miss:** go to RD_MISS; `ready` = 0.
- **IDLE, store:** go to WR_THRU; `ready` = 0.
- **RD_MISS:** `mem_req` = 1, `mem_we` = 0, `mem_be` = 1111. On `mem_ack`, fill the line (valid = 1, tag, `mem_rdata`), then go to RESPOND.
- **WR_THRU:** `mem_req` = 1, `mem_we` = 1. On `mem_ack`:
  - if the line hits, merge the enabled bytes into it;
  - the line is never allocated on a store miss;
  - then go to RESPOND.
- **RESPOND:** `ready` = 1 for one cycle, then return to IDLE.
  - Loads return the filled word, extracted and extended.
  - Stores also return `ready` = 1 here; `rdata` is don't-care.

**Size rules**
- Halfword accesses use `addr[1]`; `addr[0]` is ignored.
- Word accesses ignore `addr[1:0]`; there is no misalignment trap.
- Store byte enables:
  - sb: `1 << addr[1:0]`;
  - sh: `0011 << {addr[1],1'b0}`;
  - sw: 1111.
- `mem_wdata` = `wdata` replicated across lanes per size.

**Request stability**
- Requester rule: `req_*` stays stable from assertion until `ready` = 1.
- If `req_valid` drops mid-miss anyway, the backing transaction still completes and the line still fills; the result is discarded.
- `mem_*` outputs are registered and held stable until `mem_ack`.

**Boundary cases**
- `mem_ack` arriving in IDLE or RESPOND is ignored.
- A store that hits its own index updates the line and leaves its tag unchanged.
- A load in the cycle after a store's RESPOND sees the merged data.
- Undefined `funct3` values (011, 110, 111) are treated as word access.
- **Reset:**
  - all valid bits clear in one cycle;
  - state returns to IDLE;
  - `mem_req`, `mem_we` = 0, `mem_addr`, `mem_wdata` = 0, `mem_be` = 0000;
  - `rdata` = 0 and `ready` = 1, since it is the IDLE with no request;
  - reset mid-transaction abandons the transaction; no line update occurs.

## Timing
- **Load hit:** 0 added cycles; `rdata` and `ready` are combinational from `addr` and the line.
- **Load miss:** `mem_req` rises at edge +1. With `mem_ack` arriving N cycles after `mem_req`, `ready` goes high N+1 cycles after `mem_req`.
- **Store:** same latency as a load miss.
- **Minimum store latency:** with `mem_ack` in the first `mem_req` cycle, `ready` is high 2 cycles after issue.
- **Throughput:** back-to-back hits, one per cycle.

## Configuration
- Macro `DMEM_CACHE_STATS_EN`.
- **Defined:** adds outputs `hit_count` and `miss_count` (32-bit each).
  - Counting:
    - `hit_count` increments on each IDLE load hit;
    - `miss_count` increments on each RD_MISS entry;
    - stores are not counted.
  - Both counters reset to 0, wrap modulo 2^32, and count in the cycle the event is decided.
- **Undefined:** the ports and counters are absent; the rest of the behaviour is identical.

## Structure
- **`dmem_cache_pkg`** holds:
  - the state enum `dmem_cache_state_t`;
  - funct3 localparams `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - the function computing byte enables from funct3 and offset.
- **Sub-module `load_align`** (combinational): takes a word, offset and funct3, and produces the extended `rdata`. It is used for both hit and RESPOND paths.

## Test plan
- **Load miss then hit:** after reset, lw 0x100 with a backing value of 0xDEADBEEF and `mem_ack` 3 cycles after `mem_req`.
  - `ready` goes low, `mem_addr` = 0x100, `rdata` = 0xDEADBEEF at `ready`.
  - A repeated lw 0x100 returns `ready` = 1 in the same cycle with no `mem_req`.
- **Sign extension:** line holds 0x80FF7F01.
  - lb 0x103 → 0xFFFFFF80.
  - lbu 0x103 → 0x00000080.
  - lh 0x102 → 0xFFFF80FF.
  - lhu 0x100 → 0x00007F01.
- **Store hit merge:** sb 0x101 with `wdata` 0xAA onto 0x11223344.
  - `mem_be` = 0010, `mem_wdata` = 0xAAAAAAAA.
  - A following lw 0x100 hits and returns 0x1122AA44.
- **Store miss, no allocate:** sw 0x200 = 0x5.
  - `mem_we` = 1.
  - A following lw 0x200 misses (`mem_req` rises).
- **Conflict eviction:** with SETS = 64, lw 0x000 then lw 0x100 (same index, different tag).
  - Both miss.
  - lw 0x000 then misses again.
- **Reset mid-miss:** assert `rst` = 0 in RD_MISS before `mem_ack`.
  - `mem_req` = 0 after the reset edge.
  - A late `mem_ack` is ignored.
  - The prior line is invalid: the next lw to its address misses.

Source files
------------

// File: rtl/dmem_cache_pkg.sv
// Shared types, funct3 encodings and store-lane helpers for the MEM-stage data cache.
package dmem_cache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_MISS  = 2'd1,
    WR_THRU  = 2'd2,
    RESPOND  = 2'd3
  } dmem_cache_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    store_be = 4'b0001 << off;
      F3_H:    store_be = 4'b0011 << {off[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
    case (f3)
      F3_B:    store_lanes = {4{data[7:0]}};
      F3_H:    store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

endpackage

// File: rtl/dmem_cache_if.sv
// MEM-stage request/response port plus the backing-memory word handshake.
interface dmem_cache_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_we;
  logic [2:0]            funct3;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport slave (
    input  req_valid, req_we, funct3, addr, wdata, mem_rdata, mem_ack,
    output rdata, ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, funct3, addr, wdata, mem_rdata, mem_ack,
    input  rdata, ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/dmem_cache_load_align.sv
// Extracts the addressed byte/halfword/word from a line word and sign- or zero-extends it.
module load_align
  import dmem_cache_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    case (offset)
      2'd0:    sel_b = word[7:0];
      2'd1:    sel_b = word[15:8];
      2'd2:    sel_b = word[23:16];
      default: sel_b = word[31:24];
    endcase
    sel_h = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{sel_b[7]}}, sel_b};
      F3_BU:   data = {24'd0, sel_b};
      F3_H:    data = {{16{sel_h[15]}}, sel_h};
      F3_HU:   data = {16'd0, sel_h};
      F3_W:    data = word;
      default: data = word;
    endcase
  end
endmodule

// File: rtl/dmem_cache.sv
// Direct-mapped write-through, no-write-allocate data cache for the MEM stage.
// Optional hit/miss counters are built when DMEM_CACHE_STATS_EN is defined.
//
// state   | meaning
// IDLE    | accept request; load hits complete here combinationally
// RD_MISS | word read outstanding on backing memory; fill line on ack
// WR_THRU | store outstanding on backing memory; merge into line on ack if hit
// RESPOND | one-cycle completion (ready=1) then back to IDLE
module dmem_cache
  import dmem_cache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  dmem_cache_if.slave bus
`ifdef DMEM_CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;

  dmem_cache_state_t state, state_nxt;

  logic [SETS-1:0]       valid;
  logic [TAG_W-1:0]      tag_arr  [SETS];
  logic [DATA_WIDTH-1:0] data_arr [SETS];

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            f3_q;
  logic [DATA_WIDTH-1:0] fill_q;
  logic                  mem_req_q, mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [3:0]            mem_be_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic [IDX_W-1:0] idx, idx_q;
  logic [TAG_W-1:0] tag, tag_q;
  logic             line_hit, store_hit, issue;
  logic             rdy, rdata_en, rsp_sel;
  logic [31:0]      align_word, align_data;

  assign idx       = bus.addr[2 +: IDX_W];
  assign tag       = bus.addr[ADDR_WIDTH-1 -: TAG_W];
  assign idx_q     = addr_q[2 +: IDX_W];
  assign tag_q     = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign line_hit  = valid[idx] && (tag_arr[idx] == tag);
  assign store_hit = valid[idx_q] && (tag_arr[idx_q] == tag_q);
  assign issue     = (state == IDLE) && bus.req_valid && (bus.req_we || !line_hit);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    rdata_en  = 1'b0;
    rsp_sel   = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.req_valid) begin
          rdy = 1'b1;
        end else if (bus.req_we) begin
          state_nxt = WR_THRU;
        end else if (line_hit) begin
          rdy      = 1'b1;
          rdata_en = 1'b1;
        end else begin
          state_nxt = RD_MISS;
        end
      end
      RD_MISS: if (bus.mem_ack) state_nxt = RESPOND;
      WR_THRU: if (bus.mem_ack) state_nxt = RESPOND;
      RESPOND: begin
        rdy       = 1'b1;
        rdata_en  = 1'b1;
        rsp_sel   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request is captured at issue so a requester dropping req_valid mid-miss cannot corrupt the fill.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid       <= '0;
      addr_q      <= '0;
      f3_q        <= '0;
      fill_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (issue) begin
        addr_q      <= bus.addr;
        f3_q        <= bus.funct3;
        mem_req_q   <= 1'b1;
        mem_we_q    <= bus.req_we;
        mem_addr_q  <= {bus.addr[ADDR_WIDTH-1:2], 2'b00};
        mem_be_q    <= bus.req_we ? store_be(bus.funct3, bus.addr[1:0]) : 4'b1111;
        mem_wdata_q <= bus.req_we ? store_lanes(bus.funct3, bus.wdata) : '0;
      end
      if ((state == RD_MISS || state == WR_THRU) && bus.mem_ack) begin
        mem_req_q <= 1'b0;
        mem_we_q  <= 1'b0;
      end
      if (state == RD_MISS && bus.mem_ack) begin
        valid[idx_q] <= 1'b1;
        fill_q       <= bus.mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == RD_MISS && bus.mem_ack) begin
        tag_arr[idx_q]  <= tag_q;
        data_arr[idx_q] <= bus.mem_rdata;
      end else if (state == WR_THRU && bus.mem_ack && store_hit) begin
        for (int i = 0; i < 4; i++) begin
          if (mem_be_q[i]) data_arr[idx_q][8*i +: 8] <= mem_wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign align_word = rsp_sel ? fill_q : data_arr[idx];

  load_align u_align (
    .word   (align_word),
    .offset (rsp_sel ? addr_q[1:0] : bus.addr[1:0]),
    .funct3 (rsp_sel ? f3_q : bus.funct3),
    .data   (align_data)
  );

  assign bus.rdata     = rdata_en ? align_data : '0;
  assign bus.ready     = rdy;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

`ifdef DMEM_CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == IDLE && bus.req_valid && !bus.req_we) begin
      if (line_hit) hit_count  <= hit_count + 32'd1;
      else          miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_cache.sv
// Directed bench for dmem_cache: load results flow through an expected-value queue.
module tb_dmem_cache;
  import dmem_cache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int compared   = 0;
  int mismatched = 0;
  logic [31:0] exp_q[$];

  dmem_cache_if bus ();
`ifdef DMEM_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dmem_cache #(.SETS(64), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DMEM_CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_rdata(input string tag);
    logic [31:0] e;
    e = exp_q.pop_front();
    check({tag, ".rdata"}, bus.rdata, e);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that completes the access.
  task automatic load_hit(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] erd);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.funct3 = f3; bus.addr = a; bus.wdata = '0;
    exp_q.push_back(erd);
    @(negedge clk);
    check({tag, ".ready"}, 32'(bus.ready), 32'd1);
    check({tag, ".mem_req"}, 32'(bus.mem_req), 32'd0);
    pop_rdata(tag);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic miss_access(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input int delay,
                             input logic [31:0] mval, input logic [3:0] ebe,
                             input logic [31:0] ewd, input logic [31:0] erd);
    int lat;
    bus.req_valid = 1'b1; bus.req_we = we; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
    if (!we) exp_q.push_back(erd);
    @(negedge clk);
    check({tag, ".stall"}, 32'(bus.ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, ".mem_req"}, 32'(bus.mem_req), 32'd1);
    check({tag, ".mem_we"}, 32'(bus.mem_we), 32'(we));
    check({tag, ".mem_addr"}, bus.mem_addr, a & 32'hFFFF_FFFC);
    check({tag, ".mem_be"}, 32'(bus.mem_be), 32'(ebe));
    if (we) check({tag, ".mem_wdata"}, bus.mem_wdata, ewd);
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = mval;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    @(negedge clk);
    lat = 0;
    while (bus.ready !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd0);
    check({tag, ".req_drop"}, 32'(bus.mem_req), 32'd0);
    if (!we) pop_rdata(tag);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.funct3 = F3_W; bus.addr = '0; bus.wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.ready", 32'(bus.ready), 32'd1);
    check("rst.rdata", bus.rdata, 32'd0);
    check("rst.mem_req", 32'(bus.mem_req), 32'd0);
    check("rst.mem_we", 32'(bus.mem_we), 32'd0);
    check("rst.mem_addr", bus.mem_addr, 32'd0);
    check("rst.mem_be", 32'(bus.mem_be), 32'd0);
    check("rst.mem_wdata", bus.mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // miss then hit
    miss_access("lw_miss", 1'b0, F3_W, 32'h100, '0, 3, 32'hDEADBEEF, 4'hF, '0, 32'hDEADBEEF);
    load_hit("lw_hit", F3_W, 32'h100, 32'hDEADBEEF);

    // sign/zero extension on 0x80FF7F01
    miss_access("sw_fill", 1'b1, F3_W, 32'h100, 32'h80FF7F01, 1, '0, 4'hF, 32'h80FF7F01, '0);
    load_hit("lb", F3_B, 32'h103, 32'hFFFFFF80);
    load_hit("lbu", F3_BU, 32'h103, 32'h00000080);
    load_hit("lh", F3_H, 32'h102, 32'hFFFF80FF);
    load_hit("lh_odd", F3_H, 32'h103, 32'hFFFF80FF);
    load_hit("lhu", F3_HU, 32'h100, 32'h00007F01);

    // store hit merges
    miss_access("sw_base", 1'b1, F3_W, 32'h100, 32'h11223344, 0, '0, 4'hF, 32'h11223344, '0);
    miss_access("sb", 1'b1, F3_B, 32'h101, 32'h000000AA, 2, '0, 4'b0010, 32'hAAAAAAAA, '0);
    load_hit("lw_merge", F3_W, 32'h100, 32'h1122AA44);
    miss_access("sh", 1'b1, F3_H, 32'h102, 32'h0000BEEF, 0, '0, 4'b1100, 32'hBEEFBEEF, '0);
    load_hit("lhu_merge", F3_HU, 32'h102, 32'h0000BEEF);
    load_hit("f3_011", 3'b011, 32'h101, 32'hBEEFAA44);

    // store miss does not allocate
    miss_access("sw_miss", 1'b1, F3_W, 32'h200, 32'h5, 0, '0, 4'hF, 32'h5, '0);
    miss_access("lw_200", 1'b0, F3_W, 32'h200, '0, 1, 32'h5, 4'hF, '0, 32'h5);

    // conflict eviction on index 0
    miss_access("lw_000a", 1'b0, F3_W, 32'h000, '0, 0, 32'hA0A0A0A0, 4'hF, '0, 32'hA0A0A0A0);
    miss_access("lw_100", 1'b0, F3_W, 32'h100, '0, 2, 32'h11112222, 4'hF, '0, 32'h11112222);
    miss_access("lw_000b", 1'b0, F3_W, 32'h000, '0, 1, 32'hA0A0A0A0, 4'hF, '0, 32'hA0A0A0A0);

    // reset in the middle of a miss
    miss_access("lw_004", 1'b0, F3_W, 32'h004, '0, 0, 32'h00440044, 4'hF, '0, 32'h00440044);
    load_hit("lw_004_hit", F3_W, 32'h004, 32'h00440044);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.funct3 = F3_W; bus.addr = 32'h008;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid.req", 32'(bus.mem_req), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid.req_clr", 32'(bus.mem_req), 32'd0);
    check("rstmid.ready", 32'(bus.ready), 32'd1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    @(negedge clk);
    check("late_ack.req", 32'(bus.mem_req), 32'd0);
    check("late_ack.rdata", bus.rdata, 32'd0);
    @(posedge clk); #1;
    miss_access("lw_004_inval", 1'b0, F3_W, 32'h004, '0, 0, 32'h04040404, 4'hF, '0, 32'h04040404);
    miss_access("lw_008", 1'b0, F3_W, 32'h008, '0, 1, 32'h08080808, 4'hF, '0, 32'h08080808);
    load_hit("lw_008_hit", F3_W, 32'h008, 32'h08080808);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
